// File: rtl/approx_adder_error_monitor.sv
// Error-metrics engine for approximate adders: ED count, sum, max and
// optional sum of ED^2 (enable with `define ERR_SQUARED_EN).
module approx_adder_error_monitor #(
  parameter int W     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     num_samples_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [W-1:0]         in1_i,
  input  logic [W-1:0]         in2_i,
  input  logic [W:0]           res_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     sample_count_o,
  output logic [CNT_W-1:0]     err_count_o,
  output logic [ACC_W-1:0]     sum_ed_o,
  output logic [W:0]           max_ed_o,
  output logic [ACC_W+W:0]     sum_sq_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_err;
  logic [ACC_W-1:0] r_sum;
  logic [W:0]       r_max;
  logic [W-1:0]     r_in1;
  logic [W-1:0]     r_in2;
  logic [W:0]       r_res;
  logic             r_v1;

  logic             w_start_run;
  logic             w_accept;
  logic [W:0]       w_exact;
  logic [W:0]       w_ed;
  logic [ACC_W:0]   w_sum_ext;
  logic [ACC_W-1:0] w_sum_nxt;

  assign w_start_run = start_i && (r_state != S_RUN);
  assign ready_o     = (r_state == S_RUN) && (r_cnt < r_n);
  assign w_accept    = valid_i && ready_o;
  assign busy_o      = (r_state == S_RUN);
  assign done_o      = (r_state == S_DONE);

  assign w_exact = {1'b0, r_in1} + {1'b0, r_in2};
  assign w_ed    = (r_res >= w_exact) ? (r_res - w_exact)
                                      : (w_exact - r_res);

  // One extra carry bit detects overflow; saturate instead of wrapping.
  assign w_sum_ext = {1'b0, r_sum} + (ACC_W+1)'(w_ed);
  assign w_sum_nxt = w_sum_ext[ACC_W] ? '1 : w_sum_ext[ACC_W-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_RUN;
      S_RUN:   if ((r_cnt == r_n) && !r_v1) w_next = S_DONE;
      S_DONE:  if (start_i) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_sum   <= '0;
      r_max   <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_res   <= '0;
      r_v1    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_run) begin
        r_n   <= num_samples_i;
        r_cnt <= '0;
        r_err <= '0;
        r_sum <= '0;
        r_max <= '0;
        r_v1  <= 1'b0;
      end else begin
        r_v1 <= w_accept;
        if (w_accept) begin
          r_in1 <= in1_i;
          r_in2 <= in2_i;
          r_res <= res_i;
          r_cnt <= r_cnt + 1'b1;
        end
        if (r_v1) begin
          if (w_ed != '0) r_err <= r_err + 1'b1;
          r_sum <= w_sum_nxt;
          if (w_ed > r_max) r_max <= w_ed;
        end
      end
    end
  end

`ifdef ERR_SQUARED_EN
  localparam int SQ_W = ACC_W + W + 1;

  logic [SQ_W-1:0] r_sq;
  logic [2*W+1:0]  w_sq;
  logic [SQ_W:0]   w_sq_ext;

  assign w_sq     = w_ed * w_ed;
  assign w_sq_ext = {1'b0, r_sq} + (SQ_W+1)'(w_sq);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sq <= '0;
    end else if (w_start_run) begin
      r_sq <= '0;
    end else if (r_v1) begin
      r_sq <= w_sq_ext[SQ_W] ? '1 : w_sq_ext[SQ_W-1:0];
    end
  end

  assign sum_sq_o = r_sq;
`else
  assign sum_sq_o = '0;
`endif

  assign sample_count_o = r_cnt;
  assign err_count_o    = r_err;
  assign sum_ed_o       = r_sum;
  assign max_ed_o       = r_max;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Bench for approx_adder_error_monitor: directed + random runs,
// run-level statistics checked by a done_o-driven scoreboard.
module tb_approx_adder_error_monitor;
  localparam int W     = 16;
  localparam int CNT_W = 32;
  localparam int ACC_W = 48;
  localparam int SQ_W  = ACC_W + W + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] num_samples_i = '0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [W-1:0]     in1_i = '0;
  logic [W-1:0]     in2_i = '0;
  logic [W:0]       res_i = '0;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] sample_count_o;
  logic [CNT_W-1:0] err_count_o;
  logic [ACC_W-1:0] sum_ed_o;
  logic [W:0]       max_ed_o;
  logic [SQ_W-1:0]  sum_sq_o;

  approx_adder_error_monitor #(
    .W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .num_samples_i(num_samples_i), .valid_i(valid_i),
    .ready_o(ready_o), .in1_i(in1_i), .in2_i(in2_i),
    .res_i(res_i), .busy_o(busy_o), .done_o(done_o),
    .sample_count_o(sample_count_o), .err_count_o(err_count_o),
    .sum_ed_o(sum_ed_o), .max_ed_o(max_ed_o), .sum_sq_o(sum_sq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] err;
    logic [ACC_W-1:0] sum;
    logic [W:0]       max;
    logic [SQ_W-1:0]  sq;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int               m_cnt;
  int               m_n;
  logic [CNT_W-1:0] m_err;
  logic [ACC_W-1:0] m_sum;
  logic [W:0]       m_max;
  logic [SQ_W-1:0]  m_sq;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, ready_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_cnt"}, sample_count_o, 0);
    chk({tag, "_err"}, err_count_o, 0);
    chk({tag, "_sum"}, sum_ed_o, 0);
    chk({tag, "_max"}, max_ed_o, 0);
    chk({tag, "_sq"}, sum_sq_o, 0);
  endtask

  // Reference: error distance from plain integer arithmetic.
  task automatic model_accept(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W:0] r);
    int unsigned exact;
    int unsigned ed;
    logic [ACC_W-1:0] amax;
    logic [SQ_W-1:0]  smax;
    logic [SQ_W-1:0]  sqv;
    exact = int'(a) + int'(b);
    ed = (int'(r) >= exact) ? int'(r) - exact : exact - int'(r);
    amax = '1;
    smax = '1;
    m_cnt++;
    if (ed != 0) m_err++;
    if (m_sum > amax - ACC_W'(ed)) m_sum = amax;
    else m_sum = m_sum + ACC_W'(ed);
    if (ed > int'(m_max)) m_max = (W+1)'(ed);
`ifdef ERR_SQUARED_EN
    sqv = SQ_W'(ed) * SQ_W'(ed);
    if (m_sq > smax - sqv) m_sq = smax;
    else m_sq = m_sq + sqv;
`else
    sqv = '0;
    smax = sqv;
`endif
  endtask

  task automatic start_run(input int n);
    @(negedge clk);
    start_i = 1'b1;
    num_samples_i = n;
    @(negedge clk);
    start_i = 1'b0;
    m_n = n; m_cnt = 0;
    m_err = '0; m_sum = '0; m_max = '0; m_sq = '0;
    chk("busy_after_start", busy_o, 1);
  endtask

  task automatic sample(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] r, input bit v, input bit st);
    valid_i = v; in1_i = a; in2_i = b; res_i = r; start_i = st;
    chk("ready", ready_o, (m_cnt < m_n));
    @(negedge clk);
    start_i = 1'b0;
    if (v && m_cnt < m_n) model_accept(a, b, r);
  endtask

  task automatic finish_run();
    exp_t e;
    valid_i = 1'b0;
    e.cnt = m_cnt; e.err = m_err; e.sum = m_sum;
    e.max = m_max; e.sq = m_sq;
    q.push_back(e);
    for (int i = 0; i < 40; i++) begin
      if (done_o) break;
      @(negedge clk);
    end
    chk("done_reached", done_o, 1);
    if (!done_o) q.delete();
    @(negedge clk);
  endtask

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done_o && !prev_done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", done_o, 0);
      end else begin
        e = q.pop_front();
        chk("mon_cnt", sample_count_o, e.cnt);
        chk("mon_err", err_count_o, e.err);
        chk("mon_sum", sum_ed_o, e.sum);
        chk("mon_max", max_ed_o, e.max);
        chk("mon_sq", sum_sq_o, e.sq);
        chk("mon_ready", ready_o, 0);
        chk("mon_busy", busy_o, 0);
      end
    end
    prev_done = done_o;
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   r;
    logic [W:0]   ex;
    int           n;
    int           guard;

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    start_run(1);
    sample(16'h0003, 16'h0005, 17'h00008, 1, 0);
    finish_run();

    start_run(2);
    sample(16'hFFFF, 16'h0001, 17'h0FFFF, 1, 0);
    sample(16'h1000, 16'h1000, 17'h02400, 1, 0);
    finish_run();

    start_run(3);
    sample(16'h0010, 16'h0020, 17'h00031, 1, 0);
    sample(16'h0000, 16'h0000, 17'h00000, 0, 0);
    sample(16'h1234, 16'h4321, 17'h05500, 1, 1);
    sample(16'h0000, 16'h0000, 17'h00000, 0, 0);
    sample(16'h8000, 16'h8000, 17'h00000, 1, 0);
    sample(16'h7777, 16'h7777, 17'h0FFFF, 1, 0);
    sample(16'h7777, 16'h7777, 17'h0FFFF, 1, 0);
    finish_run();

    start_run(0);
    finish_run();
    start_run(0);
    finish_run();

    start_run(5);
    sample(16'h0100, 16'h0001, 17'h00000, 1, 0);
    sample(16'h0200, 16'h0002, 17'h00000, 1, 0);
    rst = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_zero("midrun_rst");

    start_run(1);
    sample(16'hABCD, 16'h1111, 17'h0BCDF, 1, 0);
    finish_run();

    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 12);
      start_run(n);
      guard = 0;
      while (m_cnt < m_n && guard < 200) begin
        a = W'($urandom);
        b = W'($urandom);
        ex = {1'b0, a} + {1'b0, b};
        case ($urandom_range(0, 2))
          0: r = ex;
          1: r = ex ^ (W+1)'($urandom_range(0, 255));
          default: r = (W+1)'($urandom);
        endcase
        sample(a, b, r, ($urandom_range(0, 3) != 0), 0);
        guard++;
      end
      finish_run();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
